// File: rtl/rx_ring_space_pkg.sv
// Shared constants for the RX host ring: default ring/lbuf geometry,
// FSM state encodings and a pointer alignment helper.
package rx_ring_space_pkg;

  // Default geometry: 16 MB host ring carved into 1 MB lbufs.
  localparam int RING_LOG2_DEFAULT = 24;
  localparam int LBUF_LOG2_DEFAULT = 20;

  // FSM encodings kept as plain constants so older tooling that reads
  // state values off a bus sees stable numbers.
  localparam logic [1:0] ST_OFF   = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_GRANT = 2'd2;
  localparam logic [1:0] ST_BUSY  = 2'd3;

  // Round a free-running byte pointer down to an lbuf boundary.
  function automatic logic [63:0] lbuf_align(input logic [63:0] ptr,
                                             input int          lbuf_log2);
    logic [63:0] mask;
    mask = (64'd1 << lbuf_log2) - 64'd1;
    return ptr & ~mask;
  endfunction

endpackage

// File: rtl/rx_ring_fill.sv
// Ring occupancy: turns the committed hardware pointer and the accepted
// software pointer into a count of free lbuf slots.
module rx_ring_fill
  import rx_ring_space_pkg::*;
#(
  parameter int RING_LOG2 = RING_LOG2_DEFAULT,
  parameter int LBUF_LOG2 = LBUF_LOG2_DEFAULT
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           active,
  input  logic [63:0]                    hw_ptr,
  input  logic [63:0]                    sw_eff,
  output logic [RING_LOG2-LBUF_LOG2:0]   free_now,
  output logic [RING_LOG2-LBUF_LOG2:0]   free_slots
);

  localparam int          SLOT_W     = RING_LOG2 - LBUF_LOG2 + 1;
  localparam logic [63:0] RING_BYTES = 64'd1 << RING_LOG2;

  logic [63:0] fill;

  // Bytes in flight between consumer and producer; the pointer acceptance
  // check keeps this within the ring, the guard only protects the divide.
  always_comb begin
    fill     = hw_ptr - sw_eff;
    free_now = '0;
    if (fill <= RING_BYTES) begin
      free_now = SLOT_W'((RING_BYTES - fill) >> LBUF_LOG2);
    end
  end

  // Published slot count lags the pointers by one cycle and reads zero
  // whenever the ring is switched off.
  always_ff @(posedge clk) begin
    if (rst) begin
      free_slots <= '0;
    end else if (!active) begin
      free_slots <= '0;
    end else begin
      free_slots <= free_now;
    end
  end

endmodule

// File: rtl/rx_ring_space.sv
// RX host ring space manager: hands out one lbuf at a time to the DMA
// engine, tracks the committed producer pointer and validates the
// driver's consumer pointer before trusting it.
module rx_ring_space
  import rx_ring_space_pkg::*;
#(
  parameter int RING_LOG2 = RING_LOG2_DEFAULT,
  parameter int LBUF_LOG2 = LBUF_LOG2_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [63:0]                   sw_ptr,
  input  logic [63:0]                   ring_base,
  input  logic                          ring_en,
  input  logic                          lbuf_req,
  input  logic                          lbuf_done,
  output logic                          lbuf_gnt,
  output logic [63:0]                   lbuf_addr,
  output logic [63:0]                   hw_ptr,
  output logic [RING_LOG2-LBUF_LOG2:0]  free_slots,
  output logic                          sw_err
);

  localparam logic [63:0] RING_BYTES = 64'd1 << RING_LOG2;
  localparam logic [63:0] LBUF_BYTES = 64'd1 << LBUF_LOG2;

  logic [1:0]                   state;
  logic [63:0]                  sw_eff;
  logic [63:0]                  sw_q;
  logic [63:0]                  hw_next;
  logic [63:0]                  cand;
  logic [63:0]                  ring_off;
  logic                         done_ok;
  logic                         sw_changed;
  logic                         cand_ok;
  logic [RING_LOG2-LBUF_LOG2:0] free_now;

  // Occupancy arithmetic lives in its own block; the grant decision uses
  // its combinational output so a just-consumed last slot is never granted
  // on the stale registered count.
  rx_ring_fill #(
    .RING_LOG2 (RING_LOG2),
    .LBUF_LOG2 (LBUF_LOG2)
  ) u_fill (
    .clk        (clk),
    .rst        (rst),
    .active     (state != ST_OFF),
    .hw_ptr     (hw_ptr),
    .sw_eff     (sw_eff),
    .free_now   (free_now),
    .free_slots (free_slots)
  );

  // Next-pointer and software-pointer validation: a new consumer pointer
  // may never claim more than one full ring behind the producer, measured
  // against the producer value that includes a same-cycle completion.
  always_comb begin
    done_ok    = (state == ST_BUSY) && lbuf_done;
    hw_next    = hw_ptr + (done_ok ? LBUF_BYTES : 64'd0);
    cand       = lbuf_align(sw_ptr, LBUF_LOG2);
    sw_changed = (state != ST_OFF) && (sw_ptr != sw_q);
    cand_ok    = (hw_next - cand) <= RING_BYTES;
    ring_off   = {{(64-RING_LOG2){1'b0}}, hw_ptr[RING_LOG2-1:0]};
  end

  // Grant FSM plus producer/consumer pointer registers; wrap inside the
  // ring comes for free from using only the low pointer bits as offset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_OFF;
      lbuf_gnt  <= 1'b0;
      lbuf_addr <= '0;
      hw_ptr    <= '0;
      sw_eff    <= '0;
      sw_q      <= '0;
      sw_err    <= 1'b0;
    end else begin
      sw_q     <= sw_ptr;
      lbuf_gnt <= 1'b0;
      case (state)
        ST_OFF: begin
          if (ring_en) begin
            hw_ptr <= cand;
            sw_eff <= cand;
            sw_err <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (!ring_en) begin
            state <= ST_OFF;
          end else if (lbuf_req && (free_now != '0)) begin
            lbuf_gnt  <= 1'b1;
            lbuf_addr <= ring_base + ring_off;
            state     <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          state <= ST_BUSY;
        end
        ST_BUSY: begin
          if (done_ok) begin
            hw_ptr <= hw_next;
            state  <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_OFF;
        end
      endcase
      if (sw_changed) begin
        if (cand_ok) begin
          sw_eff <= cand;
        end else begin
          sw_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rx_ring_space.sv
// Directed bench for rx_ring_space with the default 16 MB ring / 1 MB lbuf
// geometry and the ring placed at host address 0x1_0000_0000.
module tb_rx_ring_space;

  localparam logic [63:0] BASE = 64'h1_0000_0000;

  logic        clk;
  logic        rst;
  logic [63:0] sw_ptr;
  logic [63:0] ring_base;
  logic        ring_en;
  logic        lbuf_req;
  logic        lbuf_done;
  logic        lbuf_gnt;
  logic [63:0] lbuf_addr;
  logic [63:0] hw_ptr;
  logic [4:0]  free_slots;
  logic        sw_err;

  int checks;
  int errors;
  int gnt_count;
  bit got;

  rx_ring_space dut (
    .clk        (clk),
    .rst        (rst),
    .sw_ptr     (sw_ptr),
    .ring_base  (ring_base),
    .ring_en    (ring_en),
    .lbuf_req   (lbuf_req),
    .lbuf_done  (lbuf_done),
    .lbuf_gnt   (lbuf_gnt),
    .lbuf_addr  (lbuf_addr),
    .hw_ptr     (hw_ptr),
    .free_slots (free_slots),
    .sw_err     (sw_err)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle and settle just past the rising edge.
  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  // Drive the DMA/driver side inputs in one go.
  task automatic applyStimulus(input bit req, input bit done, input bit en,
                               input logic [63:0] sw);
    lbuf_req  = req;
    lbuf_done = done;
    ring_en   = en;
    sw_ptr    = sw;
  endtask

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Wait a bounded number of cycles for a grant pulse.
  task automatic waitGrant(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      stepClock();
      if (lbuf_gnt) seen = 1'b1;
    end
  endtask

  // Count grant pulses across n cycles.
  task automatic countGrants(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      stepClock();
      if (lbuf_gnt) cnt++;
    end
  endtask

  // One full request/grant/done handshake, ending back in IDLE.
  task automatic doLbuf(input string tag);
    bit seen;
    lbuf_req = 1'b1;
    waitGrant(seen);
    checkOutput(tag, 64'(seen), 64'd1);
    lbuf_req = 1'b0;
    stepClock();
    lbuf_done = 1'b1;
    stepClock();
    lbuf_done = 1'b0;
  endtask

  // Reset, then enable the ring with the consumer pointer at sw.
  task automatic restartRing(input logic [63:0] sw);
    applyStimulus(1'b0, 1'b0, 1'b1, sw);
    rst = 1'b1;
    stepClock();
    rst = 1'b0;
    stepClock();
    stepClock();
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    ring_base = BASE;
    rst       = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 64'd0);
    stepClock();
    stepClock();

    checkOutput("rst_gnt",  64'(lbuf_gnt), 64'd0);
    checkOutput("rst_addr", lbuf_addr, 64'd0);
    checkOutput("rst_hw",   hw_ptr, 64'd0);
    checkOutput("rst_free", 64'(free_slots), 64'd0);
    checkOutput("rst_err",  64'(sw_err), 64'd0);

    // First lbuf from an empty ring.
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1, 64'd0);
    stepClock();
    stepClock();
    checkOutput("empty_free", 64'(free_slots), 64'd16);
    lbuf_req = 1'b1;
    waitGrant(got);
    checkOutput("first_gnt",  64'(got), 64'd1);
    checkOutput("first_addr", lbuf_addr, BASE);
    lbuf_req = 1'b0;
    stepClock();
    checkOutput("gnt_one_cycle", 64'(lbuf_gnt), 64'd0);
    lbuf_done = 1'b1;
    stepClock();
    lbuf_done = 1'b0;
    checkOutput("first_hw", hw_ptr, 64'h10_0000);
    stepClock();
    checkOutput("first_free", 64'(free_slots), 64'd15);

    // Fill the ring completely, then free one slot and watch the wrap.
    for (int i = 1; i < 16; i++) doLbuf("fill_gnt");
    checkOutput("full_hw", hw_ptr, 64'h100_0000);
    stepClock();
    checkOutput("full_free", 64'(free_slots), 64'd0);
    lbuf_req = 1'b1;
    countGrants(5, gnt_count);
    checkOutput("full_no_gnt", 64'(gnt_count), 64'd0);
    sw_ptr = 64'h10_0000;
    waitGrant(got);
    checkOutput("wrap_gnt",  64'(got), 64'd1);
    checkOutput("wrap_addr", lbuf_addr, BASE);
    lbuf_req = 1'b0;
    stepClock();
    lbuf_done = 1'b1;
    stepClock();
    lbuf_done = 1'b0;
    checkOutput("wrap_hw", hw_ptr, 64'h110_0000);
    stepClock();
    checkOutput("wrap_free", 64'(free_slots), 64'd0);

    // Consumer pointer ahead of producer must be rejected.
    restartRing(64'd0);
    for (int i = 0; i < 3; i++) doLbuf("rej_setup_gnt");
    stepClock();
    checkOutput("rej_pre_hw",   hw_ptr, 64'h30_0000);
    checkOutput("rej_pre_free", 64'(free_slots), 64'd13);
    sw_ptr = 64'h40_0000;
    stepClock();
    stepClock();
    checkOutput("rej_err",  64'(sw_err), 64'd1);
    checkOutput("rej_free", 64'(free_slots), 64'd13);
    sw_ptr = 64'h20_0123;
    stepClock();
    stepClock();
    checkOutput("legal_after_rej_free", 64'(free_slots), 64'd15);
    checkOutput("err_sticky", 64'(sw_err), 64'd1);

    // Completion and consumer update landing in the same cycle.
    restartRing(64'd0);
    checkOutput("reenable_err", 64'(sw_err), 64'd0);
    doLbuf("same_setup_gnt");
    lbuf_req = 1'b1;
    waitGrant(got);
    checkOutput("same_gnt", 64'(got), 64'd1);
    checkOutput("same_addr", lbuf_addr, BASE + 64'h10_0000);
    lbuf_req = 1'b0;
    stepClock();
    lbuf_done = 1'b1;
    sw_ptr    = 64'h10_0000;
    stepClock();
    lbuf_done = 1'b0;
    checkOutput("same_hw", hw_ptr, 64'h20_0000);
    stepClock();
    checkOutput("same_free", 64'(free_slots), 64'd15);
    checkOutput("same_err",  64'(sw_err), 64'd0);

    // Disabling mid-transfer waits for the done, then shuts down.
    lbuf_req = 1'b1;
    waitGrant(got);
    checkOutput("dis_gnt", 64'(got), 64'd1);
    lbuf_req = 1'b0;
    stepClock();
    ring_en = 1'b0;
    stepClock();
    stepClock();
    stepClock();
    checkOutput("dis_busy_hw", hw_ptr, 64'h20_0000);
    lbuf_done = 1'b1;
    stepClock();
    lbuf_done = 1'b0;
    checkOutput("dis_done_hw", hw_ptr, 64'h30_0000);
    lbuf_req = 1'b1;
    countGrants(6, gnt_count);
    checkOutput("dis_no_gnt", 64'(gnt_count), 64'd0);
    checkOutput("dis_hw_hold", hw_ptr, 64'h30_0000);

    // Reset while BUSY, then a stray done must be ignored.
    applyStimulus(1'b0, 1'b0, 1'b1, 64'h10_0000);
    stepClock();
    checkOutput("en_load_hw", hw_ptr, 64'h10_0000);
    stepClock();
    lbuf_req = 1'b1;
    waitGrant(got);
    checkOutput("busy_rst_gnt", 64'(got), 64'd1);
    lbuf_req = 1'b0;
    stepClock();
    rst = 1'b1;
    stepClock();
    checkOutput("busy_rst_gnt0",  64'(lbuf_gnt), 64'd0);
    checkOutput("busy_rst_addr",  lbuf_addr, 64'd0);
    checkOutput("busy_rst_hw",    hw_ptr, 64'd0);
    checkOutput("busy_rst_free",  64'(free_slots), 64'd0);
    checkOutput("busy_rst_err",   64'(sw_err), 64'd0);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0, 64'h10_0000);
    stepClock();
    lbuf_done = 1'b0;
    stepClock();
    checkOutput("stray_done_hw",  hw_ptr, 64'd0);
    checkOutput("stray_done_gnt", 64'(lbuf_gnt), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
